// File: rtl/rename_core.sv
// rename_core: R10K-style rename back end (map table, free list, 64x32 PRF).
// Ports: clock/reset; rn_* rename request -> rs*/dest/told tags and grant;
//   fl_empty; cdb_en/cdb_tag wakeup; rt_en/rt_told_tag free; rd*/wr* PRF ports.
module rename_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        rn_en,
    input  logic [4:0]  rn_rs1,
    input  logic [4:0]  rn_rs2,
    input  logic [4:0]  rn_rd,
    input  logic        rn_rd_valid,
    output logic        rn_grant,
    output logic [5:0]  rs1_tag,
    output logic        rs1_ready,
    output logic [5:0]  rs2_tag,
    output logic        rs2_ready,
    output logic [5:0]  dest_tag,
    output logic [5:0]  told_tag,
    output logic        fl_empty,
    input  logic        cdb_en,
    input  logic [5:0]  cdb_tag,
    input  logic        rt_en,
    input  logic [5:0]  rt_told_tag,
    input  logic [5:0]  rd1_idx,
    input  logic [5:0]  rd2_idx,
    output logic [31:0] rd1_data,
    output logic [31:0] rd2_data,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic [31:0] wr_data
);

    logic [5:0]  map_tag [32];
    logic        map_rdy [32];
    logic [5:0]  fl      [32];
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [5:0]  count;
    logic [31:0] prf     [64];
    logic        alloc;
    logic        pop;
    logic        push;

    assign fl_empty  = (count == 6'd0);
    assign alloc     = rn_en && rn_rd_valid && (rn_rd != 5'd0);
    // an empty list never pops, even if a tag is being pushed this cycle
    assign pop       = alloc && !fl_empty;
    // tag 0 belongs to r0 forever; a full list drops extra pushes
    assign push      = rt_en && (rt_told_tag != 6'd0) && (count != 6'd32);
    assign rn_grant  = rn_en && (!alloc || !fl_empty);
    assign dest_tag  = pop ? fl[head] : 6'd0;
    assign told_tag  = pop ? map_tag[rn_rd] : 6'd0;

    assign rs1_tag   = map_tag[rn_rs1];
    assign rs2_tag   = map_tag[rn_rs2];
    assign rs1_ready = map_rdy[rn_rs1] || (cdb_en && (cdb_tag == rs1_tag));
    assign rs2_ready = map_rdy[rn_rs2] || (cdb_en && (cdb_tag == rs2_tag));

    assign rd1_data  = (rd1_idx == 6'd0) ? 32'd0 :
                       (wr_en && (wr_idx == rd1_idx)) ? wr_data : prf[rd1_idx];
    assign rd2_data  = (rd2_idx == 6'd0) ? 32'd0 :
                       (wr_en && (wr_idx == rd2_idx)) ? wr_data : prf[rd2_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                map_tag[i] <= 6'(i);
                map_rdy[i] <= 1'b1;
                fl[i]      <= 6'(i + 32);
            end
            head  <= 5'd0;
            tail  <= 5'd0;
            count <= 6'd32;
        end else begin
            if (cdb_en) begin
                for (int i = 0; i < 32; i++) begin
                    if (map_tag[i] == cdb_tag) map_rdy[i] <= 1'b1;
                end
            end
            // placed after the wakeup loop so a same-rd rename wins
            if (pop) begin
                map_tag[rn_rd] <= fl[head];
                map_rdy[rn_rd] <= 1'b0;
                head           <= head + 5'd1;
            end
            if (push) begin
                fl[tail] <= rt_told_tag;
                tail     <= tail + 5'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) prf[i] <= 32'd0;
        end else if (wr_en && (wr_idx != 6'd0)) begin
            prf[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rename_core.sv
// tb_rename_core: directed and randomized checks of rename_core against
// a queue/array reference model of map table, free list and register file.
module tb_rename_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        rn_en;
    logic [4:0]  rn_rs1, rn_rs2, rn_rd;
    logic        rn_rd_valid;
    logic        rn_grant;
    logic [5:0]  rs1_tag, rs2_tag, dest_tag, told_tag;
    logic        rs1_ready, rs2_ready, fl_empty;
    logic        cdb_en;
    logic [5:0]  cdb_tag;
    logic        rt_en;
    logic [5:0]  rt_told_tag;
    logic [5:0]  rd1_idx, rd2_idx, wr_idx;
    logic [31:0] rd1_data, rd2_data, wr_data;
    logic        wr_en;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_tag [32];
    bit          m_rdy [32];
    int          m_fl  [$];
    logic [31:0] m_prf [64];

    rename_core dut (
        .clock(clock), .reset(reset),
        .rn_en(rn_en), .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd),
        .rn_rd_valid(rn_rd_valid), .rn_grant(rn_grant),
        .rs1_tag(rs1_tag), .rs1_ready(rs1_ready),
        .rs2_tag(rs2_tag), .rs2_ready(rs2_ready),
        .dest_tag(dest_tag), .told_tag(told_tag), .fl_empty(fl_empty),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag),
        .rt_en(rt_en), .rt_told_tag(rt_told_tag),
        .rd1_idx(rd1_idx), .rd2_idx(rd2_idx),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
    );

    always #5 clock = ~clock;

    // Reference model: advance one cycle from the inputs currently driven.
    task automatic model_step();
        bit alloc, take;
        int newtag, pre_size;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_tag[i] = i;
                m_rdy[i] = 1;
            end
            m_fl.delete();
            for (int t = 32; t < 64; t++) m_fl.push_back(t);
            for (int i = 0; i < 64; i++) m_prf[i] = 0;
            return;
        end
        pre_size = m_fl.size();
        alloc = rn_en && rn_rd_valid && rn_rd != 0;
        take  = alloc && pre_size > 0;
        newtag = take ? m_fl[0] : 0;
        if (cdb_en)
            for (int i = 0; i < 32; i++)
                if (m_tag[i] == int'(cdb_tag)) m_rdy[i] = 1;
        if (take) begin
            m_tag[rn_rd] = newtag;
            m_rdy[rn_rd] = 0;
            void'(m_fl.pop_front());
        end
        if (rt_en && rt_told_tag != 0 && pre_size < 32)
            m_fl.push_back(int'(rt_told_tag));
        if (wr_en && wr_idx != 0) m_prf[wr_idx] = wr_data;
    endtask

    function automatic logic [31:0] exp_rd(input logic [5:0] idx);
        if (idx == 0) return 32'd0;
        if (wr_en && wr_idx == idx) return wr_data;
        return m_prf[idx];
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        rn_en = 0; rn_rs1 = 0; rn_rs2 = 0; rn_rd = 0; rn_rd_valid = 0;
        cdb_en = 0; cdb_tag = 0; rt_en = 0; rt_told_tag = 0;
        rd1_idx = 0; rd2_idx = 0; wr_en = 0; wr_idx = 0; wr_data = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_reset();
        int bad;
        idle_inputs();
        do_reset();
        rn_rs1 = 5;
        #1;
        n_tests++;
        if (rs1_tag !== 6'd5 || rs1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rs1: got tag %0d rdy %0b, want 5 1",
                     rs1_tag, rs1_ready);
        end
        n_tests++;
        if (fl_empty !== 1'b0 || rn_grant !== 1'b0 ||
            dest_tag !== 6'd0 || told_tag !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_idle: empty %0b grant %0b dest %0d told %0d, want 0 0 0 0",
                     fl_empty, rn_grant, dest_tag, told_tag);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd1_idx = 6'(i);
            rd2_idx = 6'(63 - i);
            #1;
            if (rd1_data !== 32'd0 || rd2_data !== 32'd0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_prf: %0d nonzero reads, want 0", bad);
        end
        idle_inputs();
    endtask

    task automatic test_rename_basic();
        rn_en = 1; rn_rd_valid = 1; rn_rd = 7; rn_rs1 = 5; rn_rs2 = 3;
        #1;
        n_tests++;
        if (rn_grant !== 1'b1 || dest_tag !== 6'd32 || told_tag !== 6'd7) begin
            n_fail++;
            $display("FAIL add_alloc: grant %0b dest %0d told %0d, want 1 32 7",
                     rn_grant, dest_tag, told_tag);
        end
        n_tests++;
        if (rs1_tag !== 6'd5 || rs1_ready !== 1'b1 ||
            rs2_tag !== 6'd3 || rs2_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_srcs: rs1 %0d/%0b rs2 %0d/%0b, want 5/1 3/1",
                     rs1_tag, rs1_ready, rs2_tag, rs2_ready);
        end
        cycle();
        rn_rd = 6; rn_rs1 = 6; rn_rs2 = 0;
        #1;
        n_tests++;
        if (dest_tag !== 6'd33 || told_tag !== 6'd6 || rs1_tag !== 6'd6) begin
            n_fail++;
            $display("FAIL addi_r6: dest %0d told %0d rs1 %0d, want 33 6 6",
                     dest_tag, told_tag, rs1_tag);
        end
        cycle();
    endtask

    task automatic test_cdb_bypass();
        rn_en = 1; rn_rd_valid = 1; rn_rd = 7; rn_rs1 = 7; rn_rs2 = 6;
        #1;
        n_tests++;
        if (rs1_tag !== 6'd32 || rs1_ready !== 1'b0 ||
            dest_tag !== 6'd34 || told_tag !== 6'd32) begin
            n_fail++;
            $display("FAIL r7_chain: rs1 %0d/%0b dest %0d told %0d, want 32/0 34 32",
                     rs1_tag, rs1_ready, dest_tag, told_tag);
        end
        cdb_en = 1; cdb_tag = 32;
        #1;
        n_tests++;
        if (rs1_ready !== 1'b1 || rs2_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cdb_bypass: rs1_rdy %0b rs2_rdy %0b, want 1 0",
                     rs1_ready, rs2_ready);
        end
        cycle();
        // r7 renamed while tag 32 completed: new mapping must stay not ready
        idle_inputs();
        rn_rs1 = 7; rn_rs2 = 6;
        #1;
        n_tests++;
        if (rs1_tag !== 6'd34 || rs1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL r7_map: got %0d/%0b, want 34/0", rs1_tag, rs1_ready);
        end
        cdb_en = 1; cdb_tag = 33;
        cycle();
        cdb_en = 0;
        #1;
        n_tests++;
        if (rs2_tag !== 6'd33 || rs2_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cdb_wake: r6 %0d/%0b, want 33/1", rs2_tag, rs2_ready);
        end
        idle_inputs();
    endtask

    task automatic test_exhaust();
        int bad;
        do_reset();
        // list is full: this push is dropped
        rt_en = 1; rt_told_tag = 9;
        cycle();
        rt_en = 0;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            rn_en = 1; rn_rd_valid = 1; rn_rd = 5'((k % 31) + 1);
            #1;
            if (rn_grant !== 1'b1 || dest_tag !== 6'(32 + k)) bad++;
            cycle();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL alloc_order: %0d wrong allocations, want 0", bad);
        end
        rn_rd = 9; rn_rs1 = 9;
        #1;
        n_tests++;
        if (fl_empty !== 1'b1 || rn_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_stall: empty %0b grant %0b, want 1 0",
                     fl_empty, rn_grant);
        end
        cycle();
        rn_en = 0;
        #1;
        n_tests++;
        if (rs1_tag !== 6'd40) begin
            n_fail++;
            $display("FAIL stall_nomap: r9 %0d, want 40", rs1_tag);
        end
        rn_en = 1; rn_rd = 0;
        #1;
        n_tests++;
        if (rn_grant !== 1'b1 || dest_tag !== 6'd0 || told_tag !== 6'd0) begin
            n_fail++;
            $display("FAIL rd0_grant: grant %0b dest %0d told %0d, want 1 0 0",
                     rn_grant, dest_tag, told_tag);
        end
        rn_rd = 5; rn_rd_valid = 0;
        #1;
        n_tests++;
        if (rn_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL nord_grant: got %0b, want 1", rn_grant);
        end
        idle_inputs();
    endtask

    task automatic test_retire_wrap();
        rn_en = 1; rn_rd_valid = 1; rn_rd = 3;
        rt_en = 1; rt_told_tag = 7;
        #1;
        n_tests++;
        if (rn_grant !== 1'b0 || fl_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL push_nobypass: grant %0b empty %0b, want 0 1",
                     rn_grant, fl_empty);
        end
        cycle();
        rt_en = 0;
        #1;
        n_tests++;
        if (fl_empty !== 1'b0 || rn_grant !== 1'b1 || dest_tag !== 6'd7) begin
            n_fail++;
            $display("FAIL retire_alloc: empty %0b grant %0b dest %0d, want 0 1 7",
                     fl_empty, rn_grant, dest_tag);
        end
        cycle();
        rn_en = 0; rt_en = 1; rt_told_tag = 12;
        cycle();
        rn_en = 1; rn_rd = 4; rt_told_tag = 13;
        #1;
        n_tests++;
        if (dest_tag !== 6'd12) begin
            n_fail++;
            $display("FAIL popush_dest: got %0d, want 12", dest_tag);
        end
        cycle();
        rt_en = 0;
        #1;
        n_tests++;
        if (fl_empty !== 1'b0 || dest_tag !== 6'd13) begin
            n_fail++;
            $display("FAIL popush_count: empty %0b dest %0d, want 0 13",
                     fl_empty, dest_tag);
        end
        cycle();
        rn_en = 0; rt_en = 1; rt_told_tag = 0;
        cycle();
        rt_en = 0;
        #1;
        n_tests++;
        if (fl_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL tag0_push: empty %0b, want 1", fl_empty);
        end
        idle_inputs();
    endtask

    task automatic test_prf();
        wr_en = 1; wr_idx = 40; wr_data = 32'hDEADBEEF; rd1_idx = 40;
        #1;
        n_tests++;
        if (rd1_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL prf_bypass: got %h, want deadbeef", rd1_data);
        end
        cycle();
        wr_en = 0;
        rd2_idx = 40;
        #1;
        n_tests++;
        if (rd1_data !== 32'hDEADBEEF || rd2_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL prf_commit: got %h %h, want deadbeef",
                     rd1_data, rd2_data);
        end
        wr_en = 1; wr_idx = 0; wr_data = 5; rd1_idx = 0; rd2_idx = 0;
        #1;
        n_tests++;
        if (rd1_data !== 32'd0 || rd2_data !== 32'd0) begin
            n_fail++;
            $display("FAIL p0_bypass: got %h %h, want 0", rd1_data, rd2_data);
        end
        cycle();
        wr_en = 0;
        #1;
        n_tests++;
        if (rd1_data !== 32'd0) begin
            n_fail++;
            $display("FAIL p0_commit: got %h, want 0", rd1_data);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        rn_en = 1; rn_rd_valid = 1; rn_rd = 2;
        wr_en = 1; wr_idx = 50; wr_data = 32'h1234;
        cycle();
        rn_rd = 2; rt_en = 1; rt_told_tag = 9; cdb_en = 1; cdb_tag = 2;
        wr_idx = 51;
        reset = 1;
        cycle();
        reset = 0;
        idle_inputs();
        rn_en = 1; rn_rd_valid = 1; rn_rd = 2; rn_rs1 = 2; rd1_idx = 50;
        #1;
        n_tests++;
        if (rs1_tag !== 6'd2 || rs1_ready !== 1'b1 ||
            dest_tag !== 6'd32 || rd1_data !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: rs1 %0d/%0b dest %0d prf %h, want 2/1 32 0",
                     rs1_tag, rs1_ready, dest_tag, rd1_data);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int bad, e_rs1, e_rs2, e_dest, e_told;
        bit alloc, e_grant, e_r1, e_r2;
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            rn_en       = ($urandom_range(0, 9) < 7);
            rn_rd_valid = ($urandom_range(0, 9) < 8);
            rn_rd       = 5'($urandom_range(0, 31));
            rn_rs1      = 5'($urandom_range(0, 31));
            rn_rs2      = ($urandom_range(0, 3) == 0) ? rn_rd
                                                      : 5'($urandom_range(0, 31));
            cdb_en      = $urandom_range(0, 1);
            cdb_tag     = 6'(m_tag[$urandom_range(0, 31)]);
            rt_en       = ($urandom_range(0, 9) < 5);
            rt_told_tag = 6'($urandom_range(0, 63));
            wr_en       = $urandom_range(0, 1);
            wr_idx      = 6'($urandom_range(0, 63));
            wr_data     = $urandom;
            rd1_idx     = ($urandom_range(0, 3) == 0) ? wr_idx
                                                      : 6'($urandom_range(0, 63));
            rd2_idx     = 6'($urandom_range(0, 63));
            #1;
            alloc   = rn_en && rn_rd_valid && rn_rd != 0;
            e_grant = rn_en && (!alloc || m_fl.size() > 0);
            e_dest  = (alloc && m_fl.size() > 0) ? m_fl[0] : 0;
            e_told  = (alloc && m_fl.size() > 0) ? m_tag[rn_rd] : 0;
            e_rs1   = m_tag[rn_rs1];
            e_rs2   = m_tag[rn_rs2];
            e_r1    = m_rdy[rn_rs1] || (cdb_en && int'(cdb_tag) == e_rs1);
            e_r2    = m_rdy[rn_rs2] || (cdb_en && int'(cdb_tag) == e_rs2);
            n_tests++;
            if (rn_grant !== e_grant || fl_empty !== (m_fl.size() == 0) ||
                dest_tag !== 6'(e_dest) || told_tag !== 6'(e_told)) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_alloc c%0d: g%0b e%0b d%0d t%0d, want g%0b e%0b d%0d t%0d",
                             c, rn_grant, fl_empty, dest_tag, told_tag,
                             e_grant, m_fl.size() == 0, e_dest, e_told);
            end
            n_tests++;
            if (rs1_tag !== 6'(e_rs1) || rs2_tag !== 6'(e_rs2) ||
                rs1_ready !== e_r1 || rs2_ready !== e_r2) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_src c%0d: %0d/%0b %0d/%0b, want %0d/%0b %0d/%0b",
                             c, rs1_tag, rs1_ready, rs2_tag, rs2_ready,
                             e_rs1, e_r1, e_rs2, e_r2);
            end
            n_tests++;
            if (rd1_data !== exp_rd(rd1_idx) || rd2_data !== exp_rd(rd2_idx)) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_prf c%0d: %h %h, want %h %h", c,
                             rd1_data, rd2_data, exp_rd(rd1_idx), exp_rd(rd2_idx));
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_rename_basic();
        test_cdb_bypass();
        test_exhaust();
        test_retire_wrap();
        test_prf();
        test_mid_reset();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_core.md
Name: rename_core

Overview:
- Register-rename back end for the R10K-style out-of-order core. Bundles three sub-blocks:
  - map table: architectural register to physical tag, plus a ready bit per entry.
  - free list: circular FIFO of unallocated physical tags.
  - physical register file (PRF): 64 x 32-bit.
- Driven by decode (rename requests), the CDB (tag broadcast), retire (freeing T_old) and issue/complete (PRF read/write).

Parameters:
- N_ARCH, 32, architectural registers; index width 5.
- N_PHYS, 64, physical registers; tag width 6.
- XLEN, 32, data width.

Ports:
- clock, input, 1, system clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- rn_en, input, 1, rename request valid this cycle.
- rn_rs1, input, 5, source 1 architectural register.
- rn_rs2, input, 5, source 2 architectural register.
- rn_rd, input, 5, destination architectural register.
- rn_rd_valid, input, 1, the instruction writes rd.
- rn_grant, output, 1, rename accepted this cycle.
- rs1_tag, output, 6, physical tag mapped to rs1.
- rs1_ready, output, 1, rs1 value is available.
- rs2_tag, output, 6, physical tag mapped to rs2.
- rs2_ready, output, 1, rs2 value is available.
- dest_tag, output, 6, newly allocated tag (T).
- told_tag, output, 6, previous mapping of rd (T_old).
- fl_empty, output, 1, free list holds no tags.
- cdb_en, input, 1, CDB broadcast valid.
- cdb_tag, input, 6, completing physical tag.
- rt_en, input, 1, retire frees a tag.
- rt_told_tag, input, 6, tag returned to the free list.
- rd1_idx, input, 6, PRF read port 1 index.
- rd2_idx, input, 6, PRF read port 2 index.
- rd1_data, output, 32, PRF read port 1 data.
- rd2_data, output, 32, PRF read port 2 data.
- wr_en, input, 1, PRF write enable.
- wr_idx, input, 6, PRF write index.
- wr_data, input, 32, PRF write data.

Behaviour:
- Reset, synchronous:
  - map[i] = {tag i, ready 1} for i = 0..31.
  - Free list holds tags 32..63 in ascending order; head = 0, tail = 0, count = 32.
  - All PRF entries = 0.
- Outputs are combinational from current state and inputs. During/after reset:
  - fl_empty = 0.
  - With rn_en = 0: rn_grant = 0, dest_tag = 0, told_tag = 0.
- Source lookup:
  - rsX_tag = map[rsX].tag.
  - rsX_ready = map[rsX].ready, OR (cdb_en && cdb_tag == map[rsX].tag), i.e. CDB bypass.
  - Lookups use pre-update state, so an instruction reading the same register it writes sees the old tag.
- Allocation condition: alloc = rn_en && rn_rd_valid && rn_rd != 0.
- rn_grant:
  - rn_grant = rn_en && (!alloc || !fl_empty).
  - No rename proceeds when alloc = 1 and the free list is empty.
- On an allocating grant:
  - dest_tag = free_list[head]; told_tag = map[rd].tag.
  - At posedge: map[rd] <= {dest_tag, ready 0}; head <= head + 1 (mod 32); count decrements.
- On a non-allocating grant: dest_tag = 0, told_tag = 0, no state change.
- Architectural r0:
  - r0 is never renamed; it stays mapped to tag 0 with ready 1.
  - Tag 0 is never pushed to the free list; rt_en with tag 0 is ignored.
- CDB: at posedge, every map entry whose tag == cdb_tag gets ready <= 1.
- Simultaneous CDB and allocating rename to the same rd: the rename wins (new tag, ready 0).
- Retire:
  - rt_en pushes rt_told_tag at the tail; tail <= tail + 1 (mod 32); count increments.
  - A push when count == 32 is ignored and count stays 32.
- Simultaneous pop and push: both happen; count is unchanged.
- When empty, a same-cycle push does not bypass into the pop. The rename stalls that cycle and the pushed tag becomes available next cycle.
- Pointers wrap modulo 32. fl_empty = (count == 0).
- PRF:
  - Reads are combinational.
  - Write-through bypass: if wr_en and wr_idx == rdX_idx and rdX_idx != 0, rdX_data = wr_data.
  - Writes commit at posedge.
  - Physical register 0 reads 0 always; writes to it are ignored.
- Reset asserted mid-operation overrides all same-cycle rename, CDB, retire and write activity.

Test Plan:
- Reset, then idle:
  - rs1 = 5 gives tag 5, ready 1.
  - fl_empty = 0; every PRF read returns 0.
- Rename add r7 <- r5, r3:
  - Combinational: grant 1, dest 32, told 7, rs1 tag 5 ready 1, rs2 tag 3 ready 1.
  - Next cycle, rename addi r6 <- r6: dest 33, told 6, rs1 tag 6.
- Rename addi r7 <- r7 after the first rename:
  - rs1 tag 32, ready 0; dest 34, told 32.
  - Drive cdb_en with tag 32 in the same cycle: rs1_ready = 1 (bypass).
  - The map entry for r7 holds 34, ready 0.
- 32 allocating renames with no retire:
  - Tags 32..63 are allocated in order, then fl_empty = 1.
  - The 33rd allocating rename: rn_grant = 0, no map change.
  - Rename with rd = 0 is still granted.
- Retire and wrap:
  - While empty, retire tag 7: next cycle fl_empty = 0 and the next allocation yields dest 7.
  - Same-cycle pop and push keeps count constant.
- PRF:
  - Write p40 = 0xDEADBEEF: same cycle, rd1_idx = 40 returns 0xDEADBEEF via bypass; it also reads back the next cycle.
  - Write p0 = 5: reads of p0 return 0.
